ps2_note_receiver: RTL and testbench
====================================

PS2_NOTE_RECEIVER -- requirements
Module: ps2_note_receiver

Interface
REQ-001 Parameter FREQ_W, default 10: width of frequency output in Hz; SHALL be >= 10.
REQ-002 Parameter TIMEOUT_CYC, default 50000: clk cycles without a ps2_clk falling edge before a partial frame is aborted.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth on ps2_clk and ps2_data; SHALL be >= 2.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous.
REQ-007 ps2_data  input  1  raw PS/2 data from keyboard, asynchronous.
REQ-008 frequency  output  FREQ_W  note frequency of the currently held key in Hz; 0 = silence.
REQ-009 note_on  output  1  high while frequency is non-zero.
REQ-010 scan_code  output  8  last correctly received byte.
REQ-011 code_valid  output  1  one-cycle pulse when scan_code updates.
REQ-012 frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through SYNC_STAGES flops; a falling edge is synchronised ps2_clk 1 -> 0 between consecutive cycles.
REQ-014 Frame FSM states IDLE, DATA, PARITY, STOP; all sampling on detected falling edges only.
REQ-015 IDLE: data 0 at falling edge -> DATA, bit count 0; data 1 -> stay IDLE, no error.
REQ-016 DATA: shift in 8 bits LSB first; after 8th bit -> PARITY.
REQ-017 PARITY: sampled bit SHALL make odd parity over 8 data bits plus parity bit; result latched -> STOP.
REQ-018 STOP: stop bit 1 and parity good -> code_valid pulse and scan_code update on the cycle after the stop edge; otherwise frame_err pulse, scan_code unchanged; either case -> IDLE.
REQ-019 Timeout counter clears on every falling edge and in IDLE; reaching TIMEOUT_CYC outside IDLE -> frame_err pulse, -> IDLE, partial byte discarded.
REQ-020 Note map (make code -> Hz): 1C->261, 1B->293, 23->329, 2B->349, 34->392, 33->440, 3B->493; all other codes unmapped.
REQ-021 Byte F0 SHALL set break_pending; the next valid byte is a release, clears break_pending, and never starts a note.
REQ-022 Byte E0 SHALL set ext_pending; the next valid byte (and a following release sequence) is ignored for note purposes; ext_pending clears after that byte.
REQ-023 Mapped make code: frequency <= mapped value, held key <= code, one cycle after code_valid; typematic repeats of the same code leave frequency unchanged.
REQ-024 Release of held key -> frequency 0; release of any other key -> no change.
REQ-025 New mapped make while another key held -> new note replaces old (last-key priority).
REQ-026 frame_err SHALL clear break_pending and ext_pending; held note unaffected.
REQ-027 Values narrower than FREQ_W are zero-extended.

Reset
REQ-028 reset low at a rising edge: FSM IDLE, bit count 0, timeout 0, synchronisers 1, frequency 0, note_on 0, scan_code 00, code_valid 0, frame_err 0, break_pending 0, ext_pending 0, held key none.
REQ-029 reset asserted mid-frame SHALL discard the partial frame with no frame_err pulse.

Configuration
REQ-030 Macro PS2_OCTAVE_SHIFT_EN defined: codes 1A (Z) and 22 (X) step octave -1/+1, clamped to range -1..+1, reset 0; frequency = base>>1, base, base<<1; held note re-scaled on the cycle after the step.
REQ-031 PS2_OCTAVE_SHIFT_EN undefined: 1A and 22 unmapped; no octave state exists; frequency = base.

Verification
REQ-032 Frame 1C with correct parity, stop 1 -> code_valid once, scan_code 1C, frequency 261, note_on 1.
REQ-033 Sequence 1C, 33, F0 1C, F0 33 -> frequency 261, 440, 440, 0.
REQ-034 Frame 23 with parity bit inverted -> frame_err once, scan_code unchanged, frequency unchanged.
REQ-035 Start + 4 data bits then ps2_clk idle TIMEOUT_CYC cycles -> frame_err once, FSM IDLE; next good frame 2B -> frequency 349.
REQ-036 E0 then 34 -> frequency unchanged; reset low mid-frame -> all outputs 0, no frame_err.
REQ-037 With PS2_OCTAVE_SHIFT_EN: 22, 22, 3B -> frequency 986; 1A -> 493; without macro 22 then 3B -> 493.

Source files
------------

// File: rtl/ps2_note_receiver.sv
// ps2_note_receiver: PS/2 keyboard frame receiver that turns make/break
// scan codes into a held musical note frequency in Hz (last-key priority).
// Optional feature macro: PS2_OCTAVE_SHIFT_EN -- when defined, codes 1A (Z)
// and 22 (X) step an octave offset within -1..+1 that scales the note.
module ps2_note_receiver #(
  parameter int FREQ_W      = 10,
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [FREQ_W-1:0] frequency,
  output logic              note_on,
  output logic [7:0]        scan_code,
  output logic              code_valid,
  output logic              frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  frame_state_t           state_r;
  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   clk_prev_r;
  logic [2:0]             bit_cnt_r;
  logic [7:0]             shift_r;
  logic                   parity_ok_r;
  logic [TO_W-1:0]        timeout_cnt_r;
  logic                   fall_s;
  logic                   bit_s;

  logic [7:0]             held_code_r;
  logic                   held_valid_r;
  logic                   break_pending_r;
  logic                   ext_pending_r;

  // Map a make code to its base note frequency; 0 means unmapped.
  function automatic logic [9:0] note_base(input logic [7:0] code);
    case (code)
      8'h1C:   note_base = 10'd261;
      8'h1B:   note_base = 10'd293;
      8'h23:   note_base = 10'd329;
      8'h2B:   note_base = 10'd349;
      8'h34:   note_base = 10'd392;
      8'h33:   note_base = 10'd440;
      8'h3B:   note_base = 10'd493;
      default: note_base = 10'd0;
    endcase
  endfunction

  // Odd parity check over the 8 data bits plus the received parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    odd_parity_ok = ^{par, data};
  endfunction

`ifdef PS2_OCTAVE_SHIFT_EN
  // Octave encoding: 0 = one down, 1 = normal, 2 = one up.
  logic [1:0] octave_r;
  logic [1:0] oct_dn_s;
  logic [1:0] oct_up_s;
  logic [9:0] held_base_r;

  function automatic logic [9:0] scale_freq(input logic [9:0] base, input logic [1:0] oct);
    case (oct)
      2'd0:    scale_freq = base >> 1;
      2'd2:    scale_freq = base << 1;
      default: scale_freq = base;
    endcase
  endfunction

  // Clamped neighbour octaves for the Z / X step keys.
  always_comb begin
    oct_dn_s = octave_r;
    oct_up_s = octave_r;
    if (octave_r != 2'd0) begin
      oct_dn_s = octave_r - 2'd1;
    end else begin
      oct_dn_s = 2'd0;
    end
    if (octave_r != 2'd2) begin
      oct_up_s = octave_r + 2'd1;
    end else begin
      oct_up_s = 2'd2;
    end
  end
`endif

  assign fall_s = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
  assign bit_s  = data_sync_r[SYNC_STAGES-1];

  // Bring the asynchronous PS/2 lines into the clk domain and keep the previous clock level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync_r  <= '1;
      data_sync_r <= '1;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
      clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
    end
  end

  // Frame FSM: samples bits on falling PS/2 clock edges, aborts stalled frames.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= IDLE;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'h00;
      parity_ok_r   <= 1'b0;
      timeout_cnt_r <= '0;
      scan_code     <= 8'h00;
      code_valid    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if ((state_r == IDLE) || fall_s) begin
        timeout_cnt_r <= '0;
      end else begin
        timeout_cnt_r <= timeout_cnt_r + TO_W'(1);
      end
      if ((state_r != IDLE) && !fall_s && (timeout_cnt_r == TO_W'(TIMEOUT_CYC - 1))) begin
        frame_err <= 1'b1;
        state_r   <= IDLE;
        bit_cnt_r <= 3'd0;
      end else if (fall_s) begin
        case (state_r)
          IDLE: begin
            if (!bit_s) begin
              state_r   <= DATA;
              bit_cnt_r <= 3'd0;
            end
          end
          DATA: begin
            shift_r <= {bit_s, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              state_r   <= PARITY;
              bit_cnt_r <= 3'd0;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          PARITY: begin
            parity_ok_r <= odd_parity_ok(shift_r, bit_s);
            state_r     <= STOP;
          end
          STOP: begin
            if (bit_s && parity_ok_r) begin
              scan_code  <= shift_r;
              code_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state_r <= IDLE;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  // Note tracker: interprets accepted bytes (break/extended prefixes, makes, releases).
  always_ff @(posedge clk) begin
    if (!reset) begin
      frequency       <= '0;
      note_on         <= 1'b0;
      held_code_r     <= 8'h00;
      held_valid_r    <= 1'b0;
      break_pending_r <= 1'b0;
      ext_pending_r   <= 1'b0;
`ifdef PS2_OCTAVE_SHIFT_EN
      octave_r        <= 2'd1;
      held_base_r     <= 10'd0;
`endif
    end else if (frame_err) begin
      break_pending_r <= 1'b0;
      ext_pending_r   <= 1'b0;
    end else if (code_valid) begin
      if (ext_pending_r) begin
        // Extended key byte (or its release prefix) never affects the note.
        if (scan_code == 8'hF0) begin
          break_pending_r <= 1'b1;
        end else begin
          ext_pending_r   <= 1'b0;
          break_pending_r <= 1'b0;
        end
      end else if (scan_code == 8'hF0) begin
        break_pending_r <= 1'b1;
      end else if (scan_code == 8'hE0) begin
        ext_pending_r <= 1'b1;
      end else if (break_pending_r) begin
        break_pending_r <= 1'b0;
        if (held_valid_r && (scan_code == held_code_r)) begin
          held_valid_r <= 1'b0;
          frequency    <= '0;
          note_on      <= 1'b0;
        end
`ifdef PS2_OCTAVE_SHIFT_EN
      end else if (scan_code == 8'h1A) begin
        octave_r <= oct_dn_s;
        if (held_valid_r) begin
          frequency <= FREQ_W'(scale_freq(held_base_r, oct_dn_s));
        end
      end else if (scan_code == 8'h22) begin
        octave_r <= oct_up_s;
        if (held_valid_r) begin
          frequency <= FREQ_W'(scale_freq(held_base_r, oct_up_s));
        end
      end else if (note_base(scan_code) != 10'd0) begin
        held_code_r  <= scan_code;
        held_valid_r <= 1'b1;
        held_base_r  <= note_base(scan_code);
        frequency    <= FREQ_W'(scale_freq(note_base(scan_code), octave_r));
        note_on      <= 1'b1;
      end
`else
      end else if (note_base(scan_code) != 10'd0) begin
        held_code_r  <= scan_code;
        held_valid_r <= 1'b1;
        frequency    <= FREQ_W'(note_base(scan_code));
        note_on      <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_note_receiver.sv
// Scoreboard bench for ps2_note_receiver: stimulus pushes expected events,
// a monitor pops them when code_valid / frame_err appears.
module tb_ps2_note_receiver;

  localparam int FREQ_W  = 12;
  localparam int TIMEOUT = 300;
  localparam int HALF    = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ps2_clk = 1'b1;
  logic              ps2_data = 1'b1;
  logic [FREQ_W-1:0] frequency;
  logic              note_on;
  logic [7:0]        scan_code;
  logic              code_valid;
  logic              frame_err;

  ps2_note_receiver #(.FREQ_W(FREQ_W), .TIMEOUT_CYC(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .frequency(frequency), .note_on(note_on), .scan_code(scan_code),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] scan;
    int         freq;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  int         note_hz [int];
  int         m_freq;
  int         m_held;
  int         m_base;
  int         m_oct;
  bit         m_brk;
  bit         m_ext;
  logic [7:0] m_scan;

  function void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endfunction

  function void model_reset();
    m_freq = 0; m_held = -1; m_base = 0; m_oct = 0;
    m_brk = 0; m_ext = 0; m_scan = 8'h00;
  endfunction

  function int scaled(int base, int oct);
    if (oct < 0) return base / 2;
    if (oct > 0) return base * 2;
    return base;
  endfunction

  function void model_byte(logic [7:0] b);
    int code;
    code = int'(b);
    if (m_ext) begin
      if (code == 'hF0) m_brk = 1;
      else begin m_ext = 0; m_brk = 0; end
    end else if (code == 'hF0) begin
      m_brk = 1;
    end else if (code == 'hE0) begin
      m_ext = 1;
    end else if (m_brk) begin
      m_brk = 0;
      if (m_held == code) begin m_held = -1; m_freq = 0; end
`ifdef PS2_OCTAVE_SHIFT_EN
    end else if (code == 'h1A || code == 'h22) begin
      m_oct = (code == 'h1A) ? ((m_oct > -1) ? m_oct - 1 : -1) : ((m_oct < 1) ? m_oct + 1 : 1);
      if (m_held >= 0) m_freq = scaled(m_base, m_oct);
`endif
    end else if (note_hz.exists(code)) begin
      m_held = code; m_base = note_hz[code]; m_freq = scaled(m_base, m_oct);
    end
  endfunction

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // err: 0 good frame, 1 parity inverted, 2 stop bit 0
  task automatic send_frame(input logic [7:0] b, input int err);
    exp_t e;
    logic par;
    if (err != 0) begin
      m_brk = 0; m_ext = 0;
      e.is_err = 1'b1;
    end else begin
      m_scan = b;
      model_byte(b);
      e.is_err = 1'b0;
    end
    e.scan = m_scan;
    e.freq = m_freq;
    exp_q.push_back(e);
    par = ~(^b);
    if (err == 1) par = ~par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit((err == 2) ? 1'b0 : 1'b1);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frequency"}, frequency, 0);
    check({tag, "_note_on"}, note_on, 0);
    check({tag, "_scan_code"}, scan_code, 0);
    check({tag, "_code_valid"}, code_valid, 0);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  // Monitor: pops an expectation whenever the DUT reports a byte or an error.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && (code_valid || frame_err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event code_valid=%0b frame_err=%0b required=none", code_valid, frame_err);
        end else begin
          e = exp_q.pop_front();
          check("event_is_err", frame_err, e.is_err);
          check("single_pulse", code_valid & frame_err, 0);
          check("scan_code", scan_code, e.scan);
          @(negedge clk);
          check("frequency", frequency, e.freq);
          check("note_on", note_on, (e.freq != 0));
          check("pulse_width", code_valid | frame_err, 0);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    logic [7:0] pool [12];
    note_hz['h1C] = 261; note_hz['h1B] = 293; note_hz['h23] = 329; note_hz['h2B] = 349;
    note_hz['h34] = 392; note_hz['h33] = 440; note_hz['h3B] = 493;
    pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'hF0, 8'hE0, 8'h1A, 8'h22, 8'h00};
    model_reset();

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Single key, chord with releases
    send_frame(8'h1C, 0);
    send_frame(8'h33, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h33, 0);
    // Bad parity, then a typematic repeat of a fresh key
    send_frame(8'h34, 0);
    send_frame(8'h23, 1);
    send_frame(8'h34, 0);

    // Timeout: start + 4 data bits, then ps2_clk idles
    m_brk = 0; m_ext = 0;
    exp_q.push_back('{1'b1, m_scan, m_freq});
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk);
    send_frame(8'h2B, 0);

    // Extended prefix swallows the next byte
    send_frame(8'hE0, 0);
    send_frame(8'h34, 0);

`ifdef PS2_OCTAVE_SHIFT_EN
    send_frame(8'h22, 0);
    send_frame(8'h22, 0);
    send_frame(8'h3B, 0);
    send_frame(8'h1A, 0);
`else
    send_frame(8'h22, 0);
    send_frame(8'h3B, 0);
`endif
    send_frame(8'hF0, 0);
    send_frame(8'h44, 2);
    send_frame(8'h1B, 0);

    // Reset in the middle of a frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    reset = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("midreset");
    model_reset();
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_all_zero("postreset");
    send_frame(8'h1B, 0);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      int err;
      b = pool[$urandom_range(0, 11)];
      if (b == 8'h00) b = 8'($urandom_range(0, 255));
      err = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_frame(b, err);
    end

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 1000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("queue_drained", exp_q.size(), 0);
    check("final_frequency", frequency, m_freq);
    check("final_scan_code", scan_code, m_scan);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
